// File: rtl/tank_sprite_engine.sv
// rtl/tank_sprite_engine.sv - per-line OAM scan into a slot cache plus a 3-stage sprite pixel pipeline
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   video_on, x, y       raster timing: active area flag and current pixel coordinate
//   oam_addr, oam_data   OAM read port (data valid one cycle after address)
//   rom_x, rom_y,        sprite sheet address and object type selecting the ROM
//   rom_sel, rom_color   (ROM pixel returns one cycle after address)
//   sprite_on, color     sprite pixel present / colour, 3 cycles after x
//   overflow             more objects than cache slots on the current line
//   scan_busy            OAM scan (SCAN or COMMIT) in progress
module tank_sprite_engine #(
    parameter int          NUM_OBJ      = 8,
    parameter int          MAX_PER_LINE = 4,
    parameter int          TILE_W       = 32,
    parameter int          TILE_H       = 32,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_TOTAL      = 525,
    parameter logic [11:0] COLOR_KEY    = 12'h00F
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          video_on,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    output logic [$clog2(NUM_OBJ)-1:0]    oam_addr,
    input  logic [31:0]                   oam_data,
    output logic [$clog2(8*TILE_W)-1:0]   rom_x,
    output logic [$clog2(8*TILE_H)-1:0]   rom_y,
    output logic [1:0]                    rom_sel,
    input  logic [11:0]                   rom_color,
    output logic                          sprite_on,
    output logic [11:0]                   color,
    output logic                          overflow,
    output logic                          scan_busy
);

    localparam int AW  = $clog2(NUM_OBJ);
    localparam int CW  = $clog2(NUM_OBJ + 1);
    localparam int SW  = $clog2(MAX_PER_LINE + 1);
    localparam int XOW = $clog2(TILE_W);
    localparam int YOW = $clog2(TILE_H);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;     // cycles spent in SCAN; entry cnt-1 is on oam_data
    logic [10:0]   yn;      // line being prepared

    // Shadow cache, filled during SCAN
    logic           sh_valid [MAX_PER_LINE];
    logic [1:0]     sh_type  [MAX_PER_LINE];
    logic [9:0]     sh_x     [MAX_PER_LINE];
    logic [YOW-1:0] sh_yoff  [MAX_PER_LINE];
    logic [2:0]     sh_row   [MAX_PER_LINE];
    logic [2:0]     sh_col   [MAX_PER_LINE];
    logic [SW-1:0]  sh_cnt;
    logic           sh_ovf;

    // Active cache, read by the pixel pipeline
    logic           ac_valid [MAX_PER_LINE];
    logic [1:0]     ac_type  [MAX_PER_LINE];
    logic [9:0]     ac_x     [MAX_PER_LINE];
    logic [YOW-1:0] ac_yoff  [MAX_PER_LINE];
    logic [2:0]     ac_row   [MAX_PER_LINE];
    logic [2:0]     ac_col   [MAX_PER_LINE];

    // OAM entry evaluation; all vertical compares at 11 bits so pos_y+TILE_H never wraps
    logic [10:0]    ent_y;
    logic           ent_hit;
    logic [YOW-1:0] ent_yoff;
    logic [2:0]     unused_oam_bits;

    assign ent_y           = {1'b0, oam_data[17:8]};
    assign ent_hit         = oam_data[28] && (oam_data[30:29] != 2'b11) &&
                             (yn >= ent_y) && (yn < ent_y + 11'(TILE_H));
    assign ent_yoff        = YOW'(yn - ent_y);
    assign unused_oam_bits = {oam_data[31], oam_data[7:6]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            oam_addr  <= '0;
            yn        <= '0;
            sh_cnt    <= '0;
            sh_ovf    <= 1'b0;
            overflow  <= 1'b0;
            scan_busy <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                sh_valid[i] <= 1'b0;
                sh_type[i]  <= '0;
                sh_x[i]     <= '0;
                sh_yoff[i]  <= '0;
                sh_row[i]   <= '0;
                sh_col[i]   <= '0;
                ac_valid[i] <= 1'b0;
                ac_type[i]  <= '0;
                ac_x[i]     <= '0;
                ac_yoff[i]  <= '0;
                ac_row[i]   <= '0;
                ac_col[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if ({1'b0, x} == 11'(H_ACTIVE)) begin
                        state     <= SCAN;
                        scan_busy <= 1'b1;
                        cnt       <= '0;
                        oam_addr  <= '0;
                        yn        <= ({1'b0, y} == 11'(V_TOTAL - 1)) ? 11'd0 : ({1'b0, y} + 11'd1);
                        sh_cnt    <= '0;
                        sh_ovf    <= 1'b0;
                        for (int i = 0; i < MAX_PER_LINE; i++) begin
                            sh_valid[i] <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    // cnt==0 is the first address cycle; no data returned yet
                    if (cnt != '0 && ent_hit) begin
                        if (sh_cnt < SW'(MAX_PER_LINE)) begin
                            for (int i = 0; i < MAX_PER_LINE; i++) begin
                                if (sh_cnt == SW'(i)) begin
                                    sh_valid[i] <= 1'b1;
                                    sh_type[i]  <= oam_data[30:29];
                                    sh_x[i]     <= oam_data[27:18];
                                    sh_yoff[i]  <= ent_yoff;
                                    sh_row[i]   <= oam_data[5:3];
                                    sh_col[i]   <= oam_data[2:0];
                                end
                            end
                            sh_cnt <= sh_cnt + SW'(1);
                        end else begin
                            sh_ovf <= 1'b1;
                        end
                    end
                    if (cnt == CW'(NUM_OBJ)) begin
                        state <= COMMIT;
                    end
                    cnt      <= cnt + CW'(1);
                    oam_addr <= (cnt < CW'(NUM_OBJ - 1)) ? oam_addr + AW'(1) : '0;
                end
                COMMIT: begin
                    for (int i = 0; i < MAX_PER_LINE; i++) begin
                        ac_valid[i] <= sh_valid[i];
                        ac_type[i]  <= sh_type[i];
                        ac_x[i]     <= sh_x[i];
                        ac_yoff[i]  <= sh_yoff[i];
                        ac_row[i]   <= sh_row[i];
                        ac_col[i]   <= sh_col[i];
                    end
                    overflow  <= sh_ovf;
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                    cnt       <= '0;
                end
                default: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 slot match: descending loop so the lowest slot index wins
    logic           m_found;
    logic [1:0]     m_type;
    logic [XOW-1:0] m_xoff;
    logic [YOW-1:0] m_yoff;
    logic [2:0]     m_row;
    logic [2:0]     m_col;

    always_comb begin
        m_found = 1'b0;
        m_type  = '0;
        m_xoff  = '0;
        m_yoff  = '0;
        m_row   = '0;
        m_col   = '0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (ac_valid[i] && ({1'b0, x} >= {1'b0, ac_x[i]}) &&
                ({1'b0, x} < {1'b0, ac_x[i]} + 11'(TILE_W))) begin
                m_found = 1'b1;
                m_type  = ac_type[i];
                m_xoff  = XOW'(x - ac_x[i]);
                m_yoff  = ac_yoff[i];
                m_row   = ac_row[i];
                m_col   = ac_col[i];
            end
        end
    end

    logic hit1;
    logic hit2;
    logic opaque;

    // hit2 lines up with rom_color; a transparent winner blanks the pixel
    assign opaque = hit2 && (rom_color != COLOR_KEY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_x     <= '0;
            rom_y     <= '0;
            rom_sel   <= '0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            sprite_on <= 1'b0;
            color     <= '0;
        end else begin
            // ROM address holds when nothing is drawn
            if (m_found && video_on) begin
                rom_x   <= {m_col, m_xoff};
                rom_y   <= {m_row, m_yoff};
                rom_sel <= m_type;
            end
            hit1      <= m_found && video_on;
            hit2      <= hit1;
            sprite_on <= opaque;
            color     <= opaque ? rom_color : 12'h000;
        end
    end

endmodule

// File: tb/tb_tank_sprite_engine.sv
// tb/tb_tank_sprite_engine.sv - directed self-checking bench for tank_sprite_engine
module tb_tank_sprite_engine;

    localparam int NUM_OBJ  = 8;
    localparam int H_ACTIVE = 640;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [2:0]  oam_addr;
    logic [31:0] oam_data = '0;
    logic [7:0]  rom_x;
    logic [7:0]  rom_y;
    logic [1:0]  rom_sel;
    logic [11:0] rom_color = '0;
    logic        sprite_on;
    logic [11:0] color;
    logic        overflow;
    logic        scan_busy;

    int passed = 0;
    int total  = 0;

    logic [31:0] oam [NUM_OBJ];
    logic [11:0] rom_val = 12'h0F0;
    logic        key_en  = 1'b0;
    logic [1:0]  key_sel = 2'b00;

    tank_sprite_engine dut (
        .clk       (clk),
        .rst       (rst),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .oam_addr  (oam_addr),
        .oam_data  (oam_data),
        .rom_x     (rom_x),
        .rom_y     (rom_y),
        .rom_sel   (rom_sel),
        .rom_color (rom_color),
        .sprite_on (sprite_on),
        .color     (color),
        .overflow  (overflow),
        .scan_busy (scan_busy)
    );

    always #5 clk = ~clk;

    // Synchronous OAM and ROM models, one cycle read latency
    always @(posedge clk) begin
        oam_data  <= oam[oam_addr];
        rom_color <= (key_en && rom_sel == key_sel) ? 12'h00F : rom_val;
    end

    function automatic logic [31:0] mk(input logic [1:0] t, input logic en, input int px,
                                       input int py, input int row, input int col);
        logic [9:0] pxv;
        logic [9:0] pyv;
        logic [2:0] rv;
        logic [2:0] cv;
        pxv = px[9:0];
        pyv = py[9:0];
        rv  = row[2:0];
        cv  = col[2:0];
        return {1'b0, t, en, pxv, pyv, 2'b00, rv, cv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_oam();
        for (int i = 0; i < NUM_OBJ; i++) oam[i] = '0;
    endtask

    // Starts a scan on line yv, holding x at H_ACTIVE for 'hold' busy cycles
    task automatic do_scan(input int yv, input int hold);
        int n;
        n = 0;
        y = yv[9:0];
        x = 10'(H_ACTIVE);
        tick();
        total++; if (scan_busy !== 1'b1) $display("FAIL scan_start: scan_busy=%0b want 1", scan_busy); else passed++;
        for (int i = 0; i < 40 && scan_busy; i++) begin
            n++;
            if (n >= hold) x = '0;
            tick();
        end
        x = '0;
        total++; if (n != NUM_OBJ + 2) $display("FAIL scan_len: busy cycles=%0d want %0d", n, NUM_OBJ + 2); else passed++;
    endtask

    task automatic pix(input int xv, input logic vo);
        x = xv[9:0];
        video_on = vo;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (sprite_on !== 1'b0 || color !== 12'h000) $display("FAIL reset_pix: sprite_on=%0b color=%h want 0/000", sprite_on, color); else passed++;
        total++; if (overflow !== 1'b0 || scan_busy !== 1'b0) $display("FAIL reset_flags: overflow=%0b scan_busy=%0b want 0/0", overflow, scan_busy); else passed++;
        total++; if (oam_addr !== 3'd0 || rom_x !== 8'd0 || rom_y !== 8'd0 || rom_sel !== 2'd0) $display("FAIL reset_addr: oam_addr=%0d rom_x=%0d rom_y=%0d rom_sel=%0d want 0", oam_addr, rom_x, rom_y, rom_sel); else passed++;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_oam();
        oam[0] = mk(2'd0, 1'b1, 100, 50, 0, 0);
        rom_val = 12'h0F0;
        video_on = 1'b1;
        do_scan(49, 1);
        y = 10'd50;
        pix(0, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL basic_miss: sprite_on=%0b want 0", sprite_on); else passed++;
        x = 10'd100;
        tick(); tick();
        total++; if (sprite_on !== 1'b0) $display("FAIL basic_lat2: sprite_on=%0b want 0", sprite_on); else passed++;
        tick();
        total++; if (sprite_on !== 1'b1 || color !== 12'h0F0) $display("FAIL basic_on: sprite_on=%0b color=%h want 1/0F0", sprite_on, color); else passed++;
        total++; if (rom_x !== 8'd0 || rom_y !== 8'd0) $display("FAIL basic_addr: rom_x=%0d rom_y=%0d want 0/0", rom_x, rom_y); else passed++;
        pix(131, 1'b1);
        total++; if (sprite_on !== 1'b1 || rom_x !== 8'd31) $display("FAIL basic_right_edge: sprite_on=%0b rom_x=%0d want 1/31", sprite_on, rom_x); else passed++;
        pix(132, 1'b1);
        total++; if (sprite_on !== 1'b0 || color !== 12'h000) $display("FAIL basic_past_edge: sprite_on=%0b color=%h want 0/000", sprite_on, color); else passed++;
        total++; if (rom_x !== 8'd31) $display("FAIL basic_hold: rom_x=%0d want 31", rom_x); else passed++;
        do_scan(80, 2);
        pix(110, 1'b1);
        total++; if (sprite_on !== 1'b1 || rom_x !== 8'd10 || rom_y !== 8'd31) $display("FAIL basic_bottom_row: sprite_on=%0b rom_x=%0d rom_y=%0d want 1/10/31", sprite_on, rom_x, rom_y); else passed++;
        do_scan(81, 1);
        pix(110, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL basic_below: sprite_on=%0b want 0", sprite_on); else passed++;
    endtask

    task automatic test_priority();
        clear_oam();
        oam[2] = mk(2'd1, 1'b1, 200, 10, 0, 1);
        oam[5] = mk(2'd2, 1'b1, 200, 10, 2, 3);
        do_scan(9, 3);
        pix(210, 1'b1);
        total++; if (rom_sel !== 2'd1 || rom_x !== 8'd42 || rom_y !== 8'd0) $display("FAIL prio_addr: rom_sel=%0d rom_x=%0d rom_y=%0d want 1/42/0", rom_sel, rom_x, rom_y); else passed++;
        total++; if (sprite_on !== 1'b1 || color !== 12'h0F0) $display("FAIL prio_on: sprite_on=%0b color=%h want 1/0F0", sprite_on, color); else passed++;
        key_en = 1'b1;
        key_sel = 2'd1;
        pix(211, 1'b1);
        total++; if (sprite_on !== 1'b0 || color !== 12'h000) $display("FAIL prio_transparent: sprite_on=%0b color=%h want 0/000", sprite_on, color); else passed++;
        key_en = 1'b0;
        pix(212, 1'b0);
        total++; if (sprite_on !== 1'b0 || color !== 12'h000) $display("FAIL video_off: sprite_on=%0b color=%h want 0/000", sprite_on, color); else passed++;
        total++; if (rom_x !== 8'd43) $display("FAIL video_off_hold: rom_x=%0d want 43", rom_x); else passed++;
        video_on = 1'b1;
    endtask

    task automatic test_overflow();
        clear_oam();
        for (int i = 0; i < 4; i++) oam[i] = mk(2'd0, 1'b1, i * 40, 100, 0, 0);
        oam[6] = mk(2'd3, 1'b1, 300, 100, 0, 0);
        do_scan(99, 1);
        total++; if (overflow !== 1'b0) $display("FAIL ovf_exact4: overflow=%0b want 0", overflow); else passed++;
        for (int i = 4; i < 6; i++) oam[i] = mk(2'd0, 1'b1, i * 40, 100, 0, 0);
        do_scan(99, 1);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_six: overflow=%0b want 1", overflow); else passed++;
        pix(130, 1'b1);
        total++; if (sprite_on !== 1'b1 || rom_x !== 8'd10) $display("FAIL ovf_idx3: sprite_on=%0b rom_x=%0d want 1/10", sprite_on, rom_x); else passed++;
        pix(170, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL ovf_idx4: sprite_on=%0b want 0", sprite_on); else passed++;
        pix(210, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL ovf_idx5: sprite_on=%0b want 0", sprite_on); else passed++;
        pix(305, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL type3_hidden: sprite_on=%0b want 0", sprite_on); else passed++;
        do_scan(299, 1);
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: overflow=%0b want 0", overflow); else passed++;
    endtask

    task automatic test_wrap();
        clear_oam();
        oam[0] = mk(2'd0, 1'b1, 50, 0, 0, 0);
        oam[1] = mk(2'd1, 1'b1, 1000, 1000, 0, 0);
        do_scan(524, 1);
        pix(60, 1'b1);
        total++; if (sprite_on !== 1'b1 || rom_x !== 8'd10 || rom_y !== 8'd0) $display("FAIL wrap_line0: sprite_on=%0b rom_x=%0d rom_y=%0d want 1/10/0", sprite_on, rom_x, rom_y); else passed++;
        pix(1010, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL wrap_far: sprite_on=%0b want 0", sprite_on); else passed++;
        pix(5, 1'b1);
        total++; if (sprite_on !== 1'b0) $display("FAIL wrap_low_x: sprite_on=%0b want 0", sprite_on); else passed++;
    endtask

    task automatic test_reset_midscan();
        clear_oam();
        for (int i = 0; i < 6; i++) oam[i] = mk(2'd0, 1'b1, i * 40, 100, 0, 0);
        do_scan(99, 1);
        pix(130, 1'b1);
        total++; if (sprite_on !== 1'b1 || overflow !== 1'b1) $display("FAIL mid_pre: sprite_on=%0b overflow=%0b want 1/1", sprite_on, overflow); else passed++;
        y = 10'd99;
        x = 10'(H_ACTIVE);
        tick();
        x = 10'd130;
        tick(); tick();
        total++; if (scan_busy !== 1'b1) $display("FAIL mid_busy: scan_busy=%0b want 1", scan_busy); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (sprite_on !== 1'b0 || color !== 12'h000 || overflow !== 1'b0 || scan_busy !== 1'b0) $display("FAIL mid_reset_out: sprite_on=%0b color=%h overflow=%0b scan_busy=%0b want 0", sprite_on, color, overflow, scan_busy); else passed++;
        total++; if (oam_addr !== 3'd0 || rom_x !== 8'd0) $display("FAIL mid_reset_addr: oam_addr=%0d rom_x=%0d want 0/0", oam_addr, rom_x); else passed++;
        tick();
        rst = 1'b0;
        pix(130, 1'b1);
        tick();
        total++; if (sprite_on !== 1'b0 || overflow !== 1'b0) $display("FAIL mid_after: sprite_on=%0b overflow=%0b want 0/0", sprite_on, overflow); else passed++;
        do_scan(99, 1);
        pix(130, 1'b1);
        total++; if (sprite_on !== 1'b1 || overflow !== 1'b1) $display("FAIL mid_rescan: sprite_on=%0b overflow=%0b want 1/1", sprite_on, overflow); else passed++;
    endtask

    initial begin
        clear_oam();
        test_reset();
        test_basic();
        test_priority();
        test_overflow();
        test_wrap();
        test_reset_midscan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
